// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator: pixel-enable divider, H/V counters, blank/sync/DE
//   decode, line/frame strobes and a frame counter. The NTSC/PAL and
//   single/double scan requests are shadowed and only take effect at the frame
//   wrap, so a frame never mixes two timings.
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   pal          requested mode (1=PAL), sampled at frame wrap
//   scandouble   requested scan (1=double), sampled at frame wrap
//   ce_pix       pixel enable; counters advance only when high
//   hc, vc       horizontal pixel / vertical line index
//   hblank, hsync, vblank, vsync, de   decodes aligned with hc/vc
//   line_start   1-clk pulse with hc wrapping to 0
//   frame_start  1-clk pulse with hc and vc wrapping to 0
//   frame_cnt    frames completed, modulo 2^FCW
//   cur_pal, cur_sd   active (shadowed) mode
module video_timing_gen #(
  parameter int CW       = 10,
  parameter int FCW      = 8,
  parameter int H_TOTAL  = 638,
  parameter int H_BLK    = 529,
  parameter int H_SYN    = 544,
  parameter int H_SYE    = 590,
  parameter int NV_TOTAL = 262,
  parameter int NV_BLK   = 240,
  parameter int NV_SYN   = 245,
  parameter int NV_SYE   = 248,
  parameter int PV_TOTAL = 312,
  parameter int PV_BLK   = 300,
  parameter int PV_SYN   = 304,
  parameter int PV_SYE   = 308
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pal,
  input  logic           scandouble,
  output logic           ce_pix,
  output logic [CW-1:0]  hc,
  output logic [CW-1:0]  vc,
  output logic           hblank,
  output logic           hsync,
  output logic           vblank,
  output logic           vsync,
  output logic           de,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt,
  output logic           cur_pal,
  output logic           cur_sd
);

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] H_END = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_B   = CW'(H_BLK);
  localparam logic [CW-1:0] H_S   = CW'(H_SYN);
  localparam logic [CW-1:0] H_E   = CW'(H_SYE);

  // Vertical limit for a given mode; double scan doubles every line count.
  function automatic logic [CW-1:0] v_lim(input logic p, input logic sd,
                                          input int n, input int pv);
    int v;
    v = p ? pv : n;
    if (sd) v = v * 2;
    return v[CW-1:0];
  endfunction

  logic          div_phase;
  logic          ht_end, vt_end, wrap;
  logic [CW-1:0] vt_m1;
  logic [CW-1:0] hc_nxt, vc_nxt;
  logic          pal_nxt, sd_nxt;
  logic [CW-1:0] vb_n, vs_n, ve_n;
  logic          hblank_n, hsync_n, vblank_n, vsync_n;

  always_comb begin
    vt_m1    = v_lim(cur_pal, cur_sd, NV_TOTAL, PV_TOTAL) - ONE;
    ht_end   = (hc == H_END);
    vt_end   = (vc == vt_m1);
    wrap     = ce_pix & ht_end & vt_end;
    hc_nxt   = hc;
    vc_nxt   = vc;
    pal_nxt  = cur_pal;
    sd_nxt   = cur_sd;
    if (ce_pix) begin
      if (ht_end) begin
        hc_nxt = '0;
        vc_nxt = vt_end ? '0 : vc + ONE;
      end else begin
        hc_nxt = hc + ONE;
      end
    end
    if (wrap) begin
      pal_nxt = pal;
      sd_nxt  = scandouble;
    end
    // Decodes are taken from the next-state counters so the registered
    // flags line up with the hc/vc they are presented alongside.
    vb_n     = v_lim(pal_nxt, sd_nxt, NV_BLK, PV_BLK);
    vs_n     = v_lim(pal_nxt, sd_nxt, NV_SYN, PV_SYN);
    ve_n     = v_lim(pal_nxt, sd_nxt, NV_SYE, PV_SYE);
    hblank_n = (hc_nxt >= H_B);
    hsync_n  = (hc_nxt >= H_S) && (hc_nxt < H_E);
    vblank_n = (vc_nxt >= vb_n);
    vsync_n  = (vc_nxt >= vs_n) && (vc_nxt < ve_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_phase   <= 1'b0;
      ce_pix      <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      hblank      <= 1'b0;
      hsync       <= 1'b0;
      vblank      <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      cur_pal     <= 1'b0;
      cur_sd      <= 1'b0;
    end else begin
      // The wrap restarts the divider so the first pixel of a single-scan
      // frame still lasts two clocks, whatever the previous frame's scan was.
      if (wrap) begin
        ce_pix    <= scandouble;
        div_phase <= 1'b1;
      end else begin
        ce_pix    <= cur_sd | div_phase;
        div_phase <= ~div_phase;
      end
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      cur_pal     <= pal_nxt;
      cur_sd      <= sd_nxt;
      hblank      <= hblank_n;
      hsync       <= hsync_n;
      vblank      <= vblank_n;
      vsync       <= vsync_n;
      de          <= ~hblank_n & ~vblank_n;
      line_start  <= ce_pix & ht_end;
      frame_start <= wrap;
      if (wrap) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken raster so that whole
// frames (and a full frame-counter wrap) fit in a short run.
//   H: total 12, hblank 8..11, hsync 9..10
//   NTSC SS: 6 lines, vblank 3.., vsync 4      SD: 12 lines, vblank 6.., vsync 8..9
//   PAL  SS: 8 lines, vblank 5.., vsync 6
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       pal;
  logic       scandouble;
  logic       ce_pix;
  logic [5:0] hc, vc;
  logic       hblank, hsync, vblank, vsync, de;
  logic       line_start, frame_start;
  logic [7:0] frame_cnt;
  logic       cur_pal, cur_sd;

  int n_chk  = 0;
  int n_pass = 0;

  video_timing_gen #(
    .CW(6), .FCW(8),
    .H_TOTAL(12), .H_BLK(8), .H_SYN(9), .H_SYE(11),
    .NV_TOTAL(6), .NV_BLK(3), .NV_SYN(4), .NV_SYE(5),
    .PV_TOTAL(8), .PV_BLK(5), .PV_SYN(6), .PV_SYE(7)
  ) dut (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
    .ce_pix(ce_pix), .hc(hc), .vc(vc),
    .hblank(hblank), .hsync(hsync), .vblank(vblank), .vsync(vsync), .de(de),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .cur_pal(cur_pal), .cur_sd(cur_sd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 1000);
    if (!frame_start) chk("frame_start_timeout", int'(frame_start), 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ce"},  int'(ce_pix), 0);
    chk({tag, "_hc"},  int'(hc), 0);
    chk({tag, "_vc"},  int'(vc), 0);
    chk({tag, "_de"},  int'(de), 1);
    chk({tag, "_blk"}, int'({hblank, hsync, vblank, vsync}), 0);
    chk({tag, "_str"}, int'({line_start, frame_start}), 0);
    chk({tag, "_fc"},  int'(frame_cnt), 0);
    chk({tag, "_mode"}, int'({cur_pal, cur_sd}), 0);
  endtask

  // Release reset and check the first enable pattern, the first line wrap
  // (edge 25) and the first frame wrap (edge 145 = 72 pixels * 2 + 1).
  task automatic release_check(input string tag);
    int clks;
    int ls_seen;
    ls_seen = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk({tag, "_ce_seq"}, int'(ce_pix), (i % 2 == 0) ? 1 : 0);
      if (line_start || frame_start) ls_seen++;
    end
    clks = 4;
    while (!line_start && clks < 200) begin
      @(negedge clk);
      clks++;
    end
    chk({tag, "_no_early_strobe"}, ls_seen, 0);
    chk({tag, "_first_line_clk"}, clks, 25);
    chk({tag, "_line_hc_vc"}, int'({hc, vc}), int'({6'd0, 6'd1}));
    while (!frame_start && clks < 400) begin
      @(negedge clk);
      clks++;
    end
    chk({tag, "_first_frame_clk"}, clks, 145);
    chk({tag, "_frame_ls"}, int'(line_start), 1);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 1);
  endtask

  // Scan from one frame_start sample to the next, checking the frame period,
  // counter ranges, decode alignment and the number of idle (ce_pix=0) clocks.
  task automatic scan_frame(input string tag, input int period, input int vmax,
                            input int vb, input int vs, input int ve, input int cez);
    int clks, maxh, maxv, errs, zeros, vslo, vshi;
    bit ehb, ehs, evb, evs;
    clks = 0; maxh = 0; maxv = 0; errs = 0; zeros = 0; vslo = 99; vshi = -1;
    do begin
      if (int'(hc) > maxh) maxh = int'(hc);
      if (int'(vc) > maxv) maxv = int'(vc);
      ehb = (hc >= 6'd8);
      ehs = (hc >= 6'd9) && (hc < 6'd11);
      evb = (int'(vc) >= vb);
      evs = (int'(vc) >= vs) && (int'(vc) < ve);
      if (hblank != ehb || hsync != ehs || vblank != evb || vsync != evs ||
          de != (!ehb && !evb)) errs++;
      if (vsync) begin
        if (int'(vc) < vslo) vslo = int'(vc);
        if (int'(vc) > vshi) vshi = int'(vc);
      end
      if (!ce_pix) zeros++;
      @(negedge clk);
      clks++;
    end while (!frame_start && clks < 2000);
    chk({tag, "_period"}, clks, period);
    chk({tag, "_hmax"}, maxh, 11);
    chk({tag, "_vmax"}, maxv, vmax);
    chk({tag, "_vsync_lo"}, vslo, vs);
    chk({tag, "_vsync_hi"}, vshi, ve - 1);
    chk({tag, "_decode_errs"}, errs, 0);
    chk({tag, "_ce_idle"}, zeros, cez);
  endtask

  initial begin
    int a, b, errs, n;
    reset = 1'b0;
    pal = 1'b0;
    scandouble = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");

    release_check("rel1");                       // frame_start #1
    scan_frame("ntsc_ss", 144, 5, 3, 4, 5, 72);  // ends at #2
    chk("fc_after_ntsc", int'(frame_cnt), 2);

    repeat (40) @(negedge clk);
    pal = 1'b1;
    repeat (5) @(negedge clk);
    chk("pal_shadow_hold", int'(cur_pal), 0);
    wait_fs();                                   // #3
    chk("pal_taken", int'(cur_pal), 1);
    scan_frame("pal_ss", 192, 7, 5, 6, 7, 96);   // ends at #4

    repeat (30) @(negedge clk);
    pal = 1'b0;
    scandouble = 1'b1;
    repeat (3) @(negedge clk);
    chk("sd_shadow_hold", int'(cur_sd), 0);
    a = int'(ce_pix);
    @(negedge clk);
    b = int'(ce_pix);
    chk("ce_still_toggles", a ^ b, 1);
    wait_fs();                                   // #5
    chk("sd_taken", int'({cur_pal, cur_sd}), 1);
    scan_frame("ntsc_sd", 144, 11, 6, 8, 10, 0); // ends at #6
    chk("fc_after_sd", int'(frame_cnt), 6);

    errs = 0;
    for (int k = 7; k <= 254; k++) begin
      wait_fs();
      if (int'(frame_cnt) != k) errs++;
    end
    chk("fc_run_errs", errs, 0);
    wait_fs();
    chk("fc_255", int'(frame_cnt), 255);
    wait_fs();
    chk("fc_wrap_0", int'(frame_cnt), 0);

    scandouble = 1'b0;
    wait_fs();                                   // back to single scan
    n = 0;
    while (!(hc == 6'd5 && vc == 6'd2) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mid_frame", int'({hc, vc}), int'({6'd5, 6'd2}));
    #1 reset = 1'b0;
    #1 check_reset_state("async");
    repeat (2) @(negedge clk);
    release_check("rel2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
